bfm_img_stream_gen: RTL and testbench

Parametrised image stream source for simulation benches and on-chip self-test. It generates AXI4-Stream video frames: `tuser` marks start of frame, `tlast` marks end of line. Frames are built from configurable pixel width, pixels per beat, geometry, blanking and test pattern. The block sits at the head of a stream pipeline in place of a camera/video input and drives any downstream stream sink.

---
 rtl/bfm_img_stream_gen.sv | 172 +++++++++++++++++
 tb/tb_bfm_img_stream_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bfm_img_stream_gen.sv
// bfm_img_stream_gen: AXI4-Stream video frame generator (tuser = SOF, tlast = EOL).
// Optional beat jitter via BFM_IMG_GEN_JITTER_EN.
module bfm_img_stream_gen #(
   parameter int          DATA_W    = 16,
   parameter int          PPC       = 1,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [CNT_W-1:0]       img_width,
   input  logic [CNT_W-1:0]       img_height,
   input  logic [CNT_W-1:0]       line_space,
   input  logic [CNT_W-1:0]       frame_space,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tvalid,
   output logic [DATA_W*PPC-1:0]  m_axis_tdata,
   output logic                   m_axis_tuser,
   output logic                   m_axis_tlast,
   output logic [15:0]            frame_cnt,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, ACTIVE, LINE_GAP, FRAME_GAP} state_t;
   state_t st_q, st_d;
   logic [CNT_W-1:0] w_q, w_d, h_q, h_d, ls_q, ls_d, fs_q, fs_d;
   logic [CNT_W-1:0] col_q, col_d, row_q, row_d, gap_q, gap_d, pc, pr;
   logic [1:0] mode_q, mode_d;
   logic [DATA_W-1:0] pix_q, pix_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic [DATA_W*PPC-1:0] dat_q, dat_d;
   logic vld_q, vld_d, usr_q, usr_d, lst_q, lst_d, busy_q;
   logic fire, last_col, last_row, want, pres, jit;
   assign fire     = vld_q & m_axis_tready;
   assign last_col = col_q == w_q - 1'b1;
   assign last_row = row_q == h_q - 1'b1;
   // In ACTIVE: after an accept, present the next beat unless the line/frame ends into a gap.
   assign want     = fire ? !(last_col && (last_row || ls_q != '0)) : !vld_q;
`ifdef BFM_IMG_GEN_JITTER_EN
   logic [15:0] lfsr_q;
   logic skip_q, skip_d;
   assign jit    = lfsr_q[1:0] == 2'b00 && !skip_q;
   assign skip_d = st_q == ACTIVE && want && jit;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         lfsr_q <= LFSR_SEED;
         skip_q <= 1'b0;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         skip_q <= skip_d;
      end
`else
   logic unused_seed;
   assign jit         = 1'b0;
   assign unused_seed = ^LFSR_SEED;
`endif
   always_comb begin
      st_d   = st_q;
      w_d    = w_q;
      h_d    = h_q;
      ls_d   = ls_q;
      fs_d   = fs_q;
      mode_d = mode_q;
      col_d  = col_q;
      row_d  = row_q;
      gap_d  = gap_q;
      pix_d  = pix_q;
      fcnt_d = fcnt_q;
      dat_d  = dat_q;
      vld_d  = vld_q;
      usr_d  = usr_q;
      lst_d  = lst_q;
      pc     = col_q;
      pr     = row_q;
      pres   = 1'b0;
      case (st_q)
         IDLE:
            if (enable && img_width != '0 && img_height != '0) begin
               st_d   = ACTIVE;
               w_d    = img_width;
               h_d    = img_height;
               ls_d   = line_space;
               fs_d   = frame_space;
               mode_d = mode;
               col_d  = '0;
               row_d  = '0;
               pix_d  = '0;
            end
         ACTIVE: begin
            if (fire) begin
               pc    = last_col ? '0 : col_q + 1'b1;
               pr    = last_col ? row_q + 1'b1 : row_q;
               col_d = pc;
               row_d = pr;
               vld_d = 1'b0;
               usr_d = 1'b0;
               lst_d = 1'b0;
            end
            if (fire && last_col && last_row) begin
               fcnt_d = fcnt_q + 1'b1;
               st_d   = fs_q == '0 ? IDLE : FRAME_GAP;
               gap_d  = fs_q - 1'b1;
            end else if (fire && last_col && ls_q != '0) begin
               st_d  = LINE_GAP;
               gap_d = ls_q - 1'b1;
            end
            pres = want && !jit;
         end
         LINE_GAP:
            if (gap_q == '0) begin
               st_d = ACTIVE;
               pres = 1'b1;
            end else gap_d = gap_q - 1'b1;
         FRAME_GAP:
            if (gap_q == '0) st_d = IDLE;
            else gap_d = gap_q - 1'b1;
      endcase
      if (pres) begin
         vld_d = 1'b1;
         usr_d = pr == '0 && pc == '0;
         lst_d = pc == w_q - 1'b1;
         pix_d = pix_q + DATA_W'(PPC);
         for (int k = 0; k < PPC; k++)
            dat_d[k*DATA_W +: DATA_W] = mode_q == 2'd0 ? pix_q + DATA_W'(k) :
                                        mode_q == 2'd1 ? DATA_W'(pc) * DATA_W'(PPC) + DATA_W'(k) :
                                        mode_q == 2'd2 ? DATA_W'(pr) : DATA_W'(fcnt_q);
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st_q   <= IDLE;
         w_q    <= '0;
         h_q    <= '0;
         ls_q   <= '0;
         fs_q   <= '0;
         mode_q <= '0;
         col_q  <= '0;
         row_q  <= '0;
         gap_q  <= '0;
         pix_q  <= '0;
         fcnt_q <= '0;
         dat_q  <= '0;
         vld_q  <= 1'b0;
         usr_q  <= 1'b0;
         lst_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         w_q    <= w_d;
         h_q    <= h_d;
         ls_q   <= ls_d;
         fs_q   <= fs_d;
         mode_q <= mode_d;
         col_q  <= col_d;
         row_q  <= row_d;
         gap_q  <= gap_d;
         pix_q  <= pix_d;
         fcnt_q <= fcnt_d;
         dat_q  <= dat_d;
         vld_q  <= vld_d;
         usr_q  <= usr_d;
         lst_q  <= lst_d;
         busy_q <= st_d != IDLE;
      end
   assign m_axis_tvalid = vld_q;
   assign m_axis_tdata  = dat_q;
   assign m_axis_tuser  = usr_q;
   assign m_axis_tlast  = lst_q;
   assign frame_cnt     = fcnt_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_bfm_img_stream_gen.sv
// tb_bfm_img_stream_gen: directed + random-ready checks of bfm_img_stream_gen against a frame model.
module tb_bfm_img_stream_gen;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, tready = 1'b1;
   logic [1:0] mode = '0;
   logic [15:0] w = 16'd4, h = 16'd3, ls = '0, fs = '0;
   logic vld, usr, lst, busy, vld4, usr4, lst4, busy4;
   logic [15:0] dat, fc, fc4;
   logic [31:0] dat4;
   int n_chk = 0, n_fail = 0, fidx = 0, jit_gaps = 0;

   always #5 clk = ~clk;

   bfm_img_stream_gen dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode),
      .img_width(w), .img_height(h), .line_space(ls), .frame_space(fs),
      .m_axis_tready(tready), .m_axis_tvalid(vld), .m_axis_tdata(dat),
      .m_axis_tuser(usr), .m_axis_tlast(lst), .frame_cnt(fc), .busy(busy));

   bfm_img_stream_gen #(.DATA_W(8), .PPC(4)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode),
      .img_width(w), .img_height(h), .line_space(ls), .frame_space(fs),
      .m_axis_tready(tready), .m_axis_tvalid(vld4), .m_axis_tdata(dat4),
      .m_axis_tuser(usr4), .m_axis_tlast(lst4), .frame_cnt(fc4), .busy(busy4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pixel value from the frame rules, before modulo reduction.
   function automatic int lane(int md, int r, int c, int wd, int f, int ppc, int k);
      return md == 0 ? (r * wd + c) * ppc + k : md == 1 ? c * ppc + k : md == 2 ? r : f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int wd, input int ht, input int lsp, input int fsp,
                            input int md, input bit rnd, input int drop_at);
      int beats = 0, idle = 0, cyc = 0, gapc = 0, r, c;
      bit prev_stall = 0, prev_last = 0, fresh = 0;
      logic [17:0] prev_pay;
      logic [31:0] e4;
      w = 16'(wd); h = 16'(ht); ls = 16'(lsp); fs = 16'(fsp); mode = 2'(md); enable = 1'b1;
      while (beats < wd * ht && cyc < 20000) begin
         step();
         cyc++;
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cyc == 1) chk("latency_n", {vld, busy}, 2'b01);
`ifndef BFM_IMG_GEN_JITTER_EN
         if (cyc == 2) chk("latency_n1", vld, 1'b1);
`endif
         if (prev_stall) chk("stall_hold", {vld, usr, lst, dat}, {1'b1, prev_pay});
         if (!vld) idle++;
         else if (fresh) begin
            fresh = 0;
            if (prev_last) chk("line_gap", idle, lsp);
`ifdef BFM_IMG_GEN_JITTER_EN
            else if (idle > 0) jit_gaps++;
`else
            else chk("intra_gap", idle, 0);
`endif
         end
         if (vld && tready) begin
            r = beats / wd;
            c = beats % wd;
            chk("beat", {usr, lst, dat}, {beats == 0, c == wd - 1, 16'(lane(md, r, c, wd, fidx, 1, 0))});
            for (int k = 0; k < 4; k++) e4[k*8 +: 8] = 8'(lane(md, r, c, wd, fidx, 4, k));
            chk("beat4", {vld4, usr4, lst4, dat4}, {1'b1, beats == 0, c == wd - 1, e4});
            beats++;
            prev_last = lst;
            fresh = 1;
            idle = 0;
            if (beats == drop_at) enable = 1'b0;
         end
         prev_stall = vld && !tready;
         prev_pay = {usr, lst, dat};
      end
      if (beats < wd * ht) chk("frame_timeout", beats, wd * ht);
      enable = 1'b0;
      step();
      fidx++;
      chk("frame_cnt", {fc, fc4}, {16'(fidx), 16'(fidx)});
      chk("post_frame_valid", {vld, usr, lst}, 3'b000);
      while (busy && gapc < 1000) begin
         gapc++;
         step();
      end
      chk("frame_gap", gapc, fsp);
      chk("idle_after_frame", {busy, busy4, vld}, 3'b000);
   endtask

   initial begin
      int bad;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {vld, usr, lst, busy, dat, fc}, '0);
      rst = 1'b0;
      step();
      run_frame(4, 3, 2, 5, 0, 0, 0);
      run_frame(2, 2, 0, 0, 1, 0, 0);
      run_frame(8, 8, 1, 3, 2, 1, 0);
      run_frame(4, 4, 3, 2, 0, 1, 3);
      run_frame(3, 2, 0, 1, 3, 1, 0);
      w = 16'd4; h = 16'd4; ls = '0; fs = '0; mode = 2'd0; tready = 1'b1; enable = 1'b1;
      repeat (4) step();
      chk("pre_rst_valid", vld, 1'b1);
      #2 rst = 1'b1;
      #1 chk("rst_async", {vld, usr, lst, busy, fc, vld4}, '0);
      #1 rst = 1'b0;
      fidx = 0;
      enable = 1'b0;
      step();
      run_frame(4, 4, 0, 0, 0, 0, 0);
      w = 16'd4; h = 16'd0; enable = 1'b1;
      bad = 0;
      repeat (10) begin
         step();
         if (vld || busy) bad++;
      end
      chk("height0_idle", bad, 0);
      enable = 1'b0;
      step();
`ifdef BFM_IMG_GEN_JITTER_EN
      jit_gaps = 0;
      repeat (10) run_frame(8, 2, 1, 0, 0, 0, 0);
      chk("jitter_seen", jit_gaps > 0, 1'b1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
